dma_arbiter: RTL and testbench

DMA_ARBITER -- requirements
Module: dma_arbiter

---
 rtl/dma_arbiter.sv | 132 +++++++++++++
 tb/tb_dma_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dma_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dma_arbiter
//  Purpose  : Two-requester round-robin arbiter for a single bsg_cache-style
//             DMA channel, with one transaction outstanding at a time.
//  Revision : 1.0  initial release
// ============================================================================
module dma_arbiter #(
   parameter int dma_pkt_width_p = 33,
   parameter int data_width_p    = 64,
   parameter int beats_p         = 8
) (
   input  logic                         clk_i,
   input  logic                         reset_n_i,
   input  logic                         calib_done_i,

   input  logic [2*dma_pkt_width_p-1:0] dma_pkt_i,
   input  logic [1:0]                   dma_pkt_v_i,
   output logic [1:0]                   dma_pkt_yumi_o,

   output logic [data_width_p-1:0]      dma_data_o,
   output logic [1:0]                   dma_data_v_o,
   input  logic [1:0]                   dma_data_ready_and_i,

   input  logic [2*data_width_p-1:0]    dma_data_i,
   input  logic [1:0]                   dma_data_v_i,
   output logic [1:0]                   dma_data_yumi_o,

   output logic [dma_pkt_width_p-1:0]   mem_dma_pkt_o,
   output logic                         mem_dma_pkt_v_o,
   input  logic                         mem_dma_pkt_yumi_i,

   input  logic [data_width_p-1:0]      mem_dma_data_i,
   input  logic                         mem_dma_data_v_i,
   output logic                         mem_dma_data_ready_and_o,

   output logic [data_width_p-1:0]      mem_dma_data_o,
   output logic                         mem_dma_data_v_o,
   input  logic                         mem_dma_data_yumi_i,

   output logic                         busy_o,
   output logic                         owner_o
);

   localparam int CNT_W = (beats_p > 1) ? $clog2(beats_p) : 1;
   localparam logic [CNT_W-1:0] C_LAST_BEAT = CNT_W'(beats_p - 1);

   localparam logic [1:0] C_IDLE  = 2'd0;
   localparam logic [1:0] C_READ  = 2'd1;
   localparam logic [1:0] C_WRITE = 2'd2;

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_owner;
   logic             r_last_grant;

   logic                       w_sel;
   logic [dma_pkt_width_p-1:0] w_sel_pkt;
   logic                       w_grant_ok;
   logic                       w_accept;
   logic                       w_rd;
   logic                       w_rd_v;
   logic                       w_wr;
   logic                       w_wr_yumi;
   logic                       w_beat;

   // With both valid, the requester that did not win last time goes next.
   assign w_sel     = (&dma_pkt_v_i) ? ~r_last_grant : dma_pkt_v_i[1];
   assign w_sel_pkt = w_sel ? dma_pkt_i[2*dma_pkt_width_p-1:dma_pkt_width_p]
                            : dma_pkt_i[dma_pkt_width_p-1:0];

   // Outputs are gated by reset_n_i directly so they read 0 while reset is held.
   assign w_grant_ok      = reset_n_i & calib_done_i & (r_state == C_IDLE);
   assign mem_dma_pkt_v_o = w_grant_ok & (|dma_pkt_v_i);
   assign mem_dma_pkt_o   = mem_dma_pkt_v_o ? w_sel_pkt : '0;
   assign w_accept        = mem_dma_pkt_v_o & mem_dma_pkt_yumi_i;
   assign dma_pkt_yumi_o  = {w_accept & w_sel, w_accept & ~w_sel};

   assign w_rd                     = reset_n_i & (r_state == C_READ);
   assign w_rd_v                   = w_rd & mem_dma_data_v_i;
   assign dma_data_v_o             = {w_rd_v & r_owner, w_rd_v & ~r_owner};
   assign dma_data_o               = w_rd_v ? mem_dma_data_i : '0;
   assign mem_dma_data_ready_and_o = w_rd & (r_owner ? dma_data_ready_and_i[1]
                                                     : dma_data_ready_and_i[0]);

   assign w_wr             = reset_n_i & (r_state == C_WRITE);
   assign mem_dma_data_v_o = w_wr & (r_owner ? dma_data_v_i[1] : dma_data_v_i[0]);
   assign mem_dma_data_o   = !mem_dma_data_v_o ? '0 :
                             r_owner ? dma_data_i[2*data_width_p-1:data_width_p]
                                     : dma_data_i[data_width_p-1:0];
   assign w_wr_yumi        = w_wr & mem_dma_data_yumi_i;
   assign dma_data_yumi_o  = {w_wr_yumi & r_owner, w_wr_yumi & ~r_owner};

   assign w_beat = (w_rd_v & mem_dma_data_ready_and_o)
                 | (mem_dma_data_v_o & mem_dma_data_yumi_i);

   assign busy_o  = (r_state != C_IDLE);
   assign owner_o = r_owner;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state      <= C_IDLE;
         r_cnt        <= '0;
         r_owner      <= 1'b0;
         r_last_grant <= 1'b1;
      end else begin
         case (r_state)
            C_IDLE: begin
               if (w_accept) begin
                  r_owner      <= w_sel;
                  r_last_grant <= w_sel;
                  r_cnt        <= '0;
                  r_state      <= w_sel_pkt[dma_pkt_width_p-1] ? C_WRITE : C_READ;
               end
            end
            C_READ, C_WRITE: begin
               if (w_beat) begin
                  if (r_cnt == C_LAST_BEAT) begin
                     r_cnt   <= '0;
                     r_state <= C_IDLE;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            default: r_state <= C_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dma_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dma_arbiter
//  Purpose  : Randomised self-checking bench for dma_arbiter against a
//             transaction-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dma_arbiter;

   localparam int PW    = 33;
   localparam int DW    = 64;
   localparam int BEATS = 8;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            calib;
   logic [2*PW-1:0] pkt;
   logic [1:0]      pkt_v;
   logic [1:0]      pkt_yumi;
   logic [DW-1:0]   data_out;
   logic [1:0]      data_v_out;
   logic [1:0]      data_rdy;
   logic [2*DW-1:0] data_in;
   logic [1:0]      data_v_in;
   logic [1:0]      data_yumi;
   logic [PW-1:0]   mem_pkt;
   logic            mem_pkt_v;
   logic            mem_pkt_yumi;
   logic [DW-1:0]   mem_rdata;
   logic            mem_rdata_v;
   logic            mem_rdata_rdy;
   logic [DW-1:0]   mem_wdata;
   logic            mem_wdata_v;
   logic            mem_wdata_yumi;
   logic            busy;
   logic            owner;

   always #5 clk = ~clk;

   dma_arbiter #(
      .dma_pkt_width_p(PW),
      .data_width_p   (DW),
      .beats_p        (BEATS)
   ) u_dut (
      .clk_i                   (clk),
      .reset_n_i               (reset_n),
      .calib_done_i            (calib),
      .dma_pkt_i               (pkt),
      .dma_pkt_v_i             (pkt_v),
      .dma_pkt_yumi_o          (pkt_yumi),
      .dma_data_o              (data_out),
      .dma_data_v_o            (data_v_out),
      .dma_data_ready_and_i    (data_rdy),
      .dma_data_i              (data_in),
      .dma_data_v_i            (data_v_in),
      .dma_data_yumi_o         (data_yumi),
      .mem_dma_pkt_o           (mem_pkt),
      .mem_dma_pkt_v_o         (mem_pkt_v),
      .mem_dma_pkt_yumi_i      (mem_pkt_yumi),
      .mem_dma_data_i          (mem_rdata),
      .mem_dma_data_v_i        (mem_rdata_v),
      .mem_dma_data_ready_and_o(mem_rdata_rdy),
      .mem_dma_data_o          (mem_wdata),
      .mem_dma_data_v_o        (mem_wdata_v),
      .mem_dma_data_yumi_i     (mem_wdata_yumi),
      .busy_o                  (busy),
      .owner_o                 (owner)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Transaction-level model: 0 = idle, 1 = read, 2 = write.
   int m_mode  = 0;
   int m_own   = 0;
   int m_last  = 1;
   int m_beats = 0;
   int n_grants = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic rand_inputs(input int calib_pct);
      calib        = ($urandom_range(0, 99) < calib_pct);
      pkt          = {$urandom(), $urandom(), $urandom()};
      pkt_v        = ($urandom_range(0, 2) == 0) ? 2'b11 : 2'($urandom_range(0, 3));
      mem_pkt_yumi = $urandom_range(0, 1);
      mem_rdata    = {$urandom(), $urandom()};
      mem_rdata_v  = $urandom_range(0, 1);
      data_rdy     = 2'($urandom_range(0, 3));
      data_in      = {$urandom(), $urandom(), $urandom(), $urandom()};
      data_v_in    = 2'($urandom_range(0, 3));
      mem_wdata_yumi = $urandom_range(0, 1);
   endtask

   // Evaluate one cycle: check outputs against the model, then advance it.
   task automatic step();
      logic [1:0]    e_pyumi, e_dv, e_dyumi;
      logic          e_pv, e_rdy, e_mv, e_busy, e_own;
      logic [PW-1:0] e_pkt;
      logic [DW-1:0] e_data, e_mdata;
      int            sel;
      // A memory that only consumes a write beat when one is offered.
      if (m_mode == 2 && !data_v_in[m_own]) mem_wdata_yumi = 1'b0;
      #1;
      e_pyumi = '0; e_dv = '0; e_dyumi = '0;
      e_pv = 0; e_rdy = 0; e_mv = 0;
      e_pkt = '0; e_data = '0; e_mdata = '0;
      if (!reset_n) begin
         m_mode = 0; m_own = 0; m_last = 1; m_beats = 0;
      end
      e_busy = (m_mode != 0);
      e_own  = m_own[0];
      if (reset_n) begin
         case (m_mode)
            0: if (calib && pkt_v != 0) begin
               sel   = (pkt_v == 2'b11) ? 1 - m_last : (pkt_v[1] ? 1 : 0);
               e_pv  = 1;
               e_pkt = pkt[sel*PW +: PW];
               e_pyumi[sel] = mem_pkt_yumi;
               if (mem_pkt_yumi) begin
                  m_own = sel; m_last = sel; m_beats = 0;
                  m_mode = e_pkt[PW-1] ? 2 : 1;
                  n_grants++;
               end
            end
            1: begin
               e_dv[m_own] = mem_rdata_v;
               e_data      = mem_rdata_v ? mem_rdata : '0;
               e_rdy       = data_rdy[m_own];
               if (mem_rdata_v && data_rdy[m_own]) m_beats++;
            end
            default: begin
               e_mv           = data_v_in[m_own];
               e_mdata        = e_mv ? data_in[m_own*DW +: DW] : '0;
               e_dyumi[m_own] = mem_wdata_yumi;
               if (e_mv && mem_wdata_yumi) m_beats++;
            end
         endcase
         if (m_mode != 0 && m_beats == BEATS) begin
            m_mode = 0; m_beats = 0;
         end
      end
      check("mem_pkt_v",      mem_pkt_v,     e_pv);
      check("mem_pkt",        mem_pkt,       e_pkt);
      check("pkt_yumi",       pkt_yumi,      e_pyumi);
      check("data_v_out",     data_v_out,    e_dv);
      check("data_out",       data_out,      e_data);
      check("mem_rdata_rdy",  mem_rdata_rdy, e_rdy);
      check("mem_wdata_v",    mem_wdata_v,   e_mv);
      check("mem_wdata",      mem_wdata,     e_mdata);
      check("data_yumi",      data_yumi,     e_dyumi);
      check("busy",           busy,          e_busy);
      check("owner",          owner,         e_own);
      @(negedge clk);
   endtask

   initial begin
      reset_n = 1'b0;
      rand_inputs(100);
      @(negedge clk);
      repeat (3) step();
      reset_n = 1'b1;

      // No grants while calibration is pending, then requester 0 wins the tie.
      calib = 1'b0; pkt_v = 2'b11; mem_pkt_yumi = 1'b1;
      mem_rdata_v = 1'b0; data_v_in = 2'b00;
      repeat (20) step();
      calib = 1'b1;
      step();
      check("first_tie_owner", owner, 1'b0);

      // Requester 1 write with memory consuming every other cycle.
      while (m_mode != 0) begin
         rand_inputs(100);
         step();
      end
      pkt_v = 2'b10; pkt[2*PW-1:PW] = 33'h1_0000_1000; mem_pkt_yumi = 1'b1;
      step();
      check("write_granted", busy, 1'b1);
      for (int i = 0; i < 4 * BEATS && m_mode != 0; i++) begin
         data_in        = {$urandom(), $urandom(), $urandom(), $urandom()};
         data_v_in      = 2'b11;
         mem_wdata_yumi = i[0];
         step();
      end
      check("write_done_idle", busy, 1'b0);

      // Randomised traffic with occasional reset pulses.
      for (int c = 0; c < 4000; c++) begin
         rand_inputs(90);
         reset_n = ($urandom_range(0, 299) != 0);
         step();
      end
      reset_n = 1'b1;
      check("grants_seen", (n_grants > 50), 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
